// File: rtl/serial_mem_ctrl.sv
// Byte-serial bridge between a core's 8-bit transfer bus and a 16-bit word memory.
// Define SERIAL_MEM_CTRL_TIMEOUT_EN to add a memory-acknowledge timeout with a sticky err flag.
module serial_mem_ctrl #(
  parameter int TYPE_W      = 2,
  parameter int R_TYPE_CODE = 0,
  parameter int TO_CYCLES   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  out_bus,
  input  logic        bus_pc,
  input  logic        bus_mar,
  input  logic        bus_mdr,
  output logic [7:0]  in_bus,
  output logic        ard_data_ready,
  output logic        ard_receive_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_space,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, PC_HI, I_REQ, I_LO, I_HI, A_HI, D_CHK, ST_HI, ST_REQ, LD_REQ, LD_LO, LD_HI
  } state_t;

  localparam logic [TYPE_W-1:0] R_CODE = TYPE_W'(R_TYPE_CODE);

  state_t      state;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] word;
  logic        idx;

`ifdef SERIAL_MEM_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TO_CYCLES - 1);
  logic [7:0] to_cnt;
  logic       in_req;
  assign in_req = (state == I_REQ) || (state == LD_REQ) || (state == ST_REQ);
`else
  logic unused_cfg;
  assign unused_cfg = ^TO_CYCLES;
  assign err = 1'b0;
`endif

  // Outputs are registered: each transition loads the values the destination state presents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      addr              <= '0;
      wdata             <= '0;
      word              <= '0;
      idx               <= 1'b0;
      in_bus            <= '0;
      ard_data_ready    <= 1'b0;
      ard_receive_ready <= 1'b1;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      mem_space         <= 1'b0;
      mem_addr          <= '0;
      mem_wdata         <= '0;
`ifdef SERIAL_MEM_CTRL_TIMEOUT_EN
      to_cnt            <= '0;
      err               <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus_pc) begin
            addr[7:0]         <= out_bus;
            ard_receive_ready <= 1'b0;
            state             <= PC_HI;
          end else if (bus_mar) begin
            addr[7:0]         <= out_bus;
            ard_receive_ready <= 1'b0;
            state             <= A_HI;
          end
        end
        PC_HI: begin
          addr[15:8] <= out_bus;
          idx        <= 1'b0;
          mem_addr   <= {out_bus, addr[7:0]};
          mem_req    <= 1'b1;
          mem_we     <= 1'b0;
          mem_space  <= 1'b0;
          state      <= I_REQ;
        end
        I_REQ: begin
          if (mem_ack) begin
            word           <= mem_rdata;
            in_bus         <= mem_rdata[7:0];
            ard_data_ready <= 1'b1;
            mem_req        <= 1'b0;
            state          <= I_LO;
          end
        end
        I_LO: begin
          in_bus <= word[15:8];
          state  <= I_HI;
        end
        I_HI: begin
          in_bus         <= '0;
          ard_data_ready <= 1'b0;
          // Only the first word's type field decides whether an immediate word follows.
          if (!idx && (word[TYPE_W-1:0] != R_CODE)) begin
            idx      <= 1'b1;
            mem_addr <= addr + 16'd1;
            mem_req  <= 1'b1;
            state    <= I_REQ;
          end else begin
            ard_receive_ready <= 1'b1;
            state             <= IDLE;
          end
        end
        A_HI: begin
          addr[15:8] <= out_bus;
          state      <= D_CHK;
        end
        D_CHK: begin
          if (bus_mdr) begin
            wdata[7:0] <= out_bus;
            state      <= ST_HI;
          end else begin
            mem_addr  <= addr;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_space <= 1'b1;
            state     <= LD_REQ;
          end
        end
        ST_HI: begin
          wdata[15:8] <= out_bus;
          mem_wdata   <= {out_bus, wdata[7:0]};
          mem_addr    <= addr;
          mem_req     <= 1'b1;
          mem_we      <= 1'b1;
          mem_space   <= 1'b1;
          state       <= ST_REQ;
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req           <= 1'b0;
            mem_we            <= 1'b0;
            mem_space         <= 1'b0;
            ard_receive_ready <= 1'b1;
            state             <= IDLE;
          end
        end
        LD_REQ: begin
          if (mem_ack) begin
            word           <= mem_rdata;
            in_bus         <= mem_rdata[7:0];
            ard_data_ready <= 1'b1;
            mem_req        <= 1'b0;
            mem_space      <= 1'b0;
            state          <= LD_LO;
          end
        end
        LD_LO: begin
          in_bus <= word[15:8];
          state  <= LD_HI;
        end
        LD_HI: begin
          in_bus            <= '0;
          ard_data_ready    <= 1'b0;
          ard_receive_ready <= 1'b1;
          state             <= IDLE;
        end
        default: begin
          ard_receive_ready <= 1'b1;
          state             <= IDLE;
        end
      endcase
`ifdef SERIAL_MEM_CTRL_TIMEOUT_EN
      // A stalled request is abandoned after TO_CYCLES cycles; this overrides the case above.
      if (in_req && !mem_ack) begin
        if (to_cnt == TO_LAST) begin
          to_cnt            <= '0;
          mem_req           <= 1'b0;
          mem_we            <= 1'b0;
          mem_space         <= 1'b0;
          ard_receive_ready <= 1'b1;
          err               <= 1'b1;
          state             <= IDLE;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_serial_mem_ctrl.sv
// Self-checking bench for serial_mem_ctrl: directed vector table, reset/stray-ack/timeout
// sequences, and randomized transactions checked against a transaction-level model.
`timescale 1ns/1ps
module tb_serial_mem_ctrl;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  out_bus = '0;
  logic        bus_pc = 1'b0, bus_mar = 1'b0, bus_mdr = 1'b0;
  logic [7:0]  in_bus;
  logic        ard_data_ready, ard_receive_ready;
  logic        mem_req, mem_we, mem_space;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  serial_mem_ctrl #(.TYPE_W(2), .R_TYPE_CODE(0), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .out_bus(out_bus), .bus_pc(bus_pc), .bus_mar(bus_mar),
    .bus_mdr(bus_mdr), .in_bus(in_bus), .ard_data_ready(ard_data_ready),
    .ard_receive_ready(ard_receive_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_space(mem_space), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        space;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  typedef struct {
    int          kind;   // 0 fetch, 1 store, 2 load
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] m0;
    logic [15:0] m1;
    int          nb;
    logic [31:0] bytes;  // first byte in bits [7:0]
    int          na;
    logic [15:0] a0;
    logic [15:0] a1;
  } vec_t;

  logic [15:0] mem [0:65535];
  logic [7:0]  got_b[$], exp_b[$];
  acc_t        got_a[$], exp_a[$];
  int          vectors = 0, miscompares = 0;
  bit          hold_off = 1'b0, stray = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Memory responder: random latency, logs every acknowledged access, checks request stability.
  initial begin : responder
    bit   in_req = 1'b0;
    int   lat = 0, waited = 0;
    acc_t rec;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!in_req) begin
          in_req = 1'b1;
          rec    = {mem_we, mem_space, mem_addr, mem_wdata};
          lat    = $urandom_range(0, 3);
          waited = 0;
        end else begin
          check("req_stable", {mem_we, mem_space, mem_addr, mem_wdata}, rec);
        end
        if (!hold_off && waited >= lat && !mem_ack) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            mem_rdata     = 16'($urandom);
          end else begin
            mem_rdata = mem[mem_addr];
          end
          got_a.push_back(rec);
        end else begin
          mem_ack = 1'b0;
          waited++;
        end
      end else begin
        in_req    = 1'b0;
        mem_ack   = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = 16'($urandom);
      end
    end
  end

  initial begin : byte_monitor
    forever begin
      @(negedge clk);
      if (ard_data_ready) got_b.push_back(in_bus);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int i;
    for (i = 0; i < 600; i++) begin
      @(negedge clk);
      if (ard_receive_ready) break;
      bus_pc  = 1'($urandom);
      bus_mar = 1'($urandom);
      bus_mdr = 1'($urandom);
      out_bus = 8'($urandom);
    end
    bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0;
    if (i == 600) check("idle_wait", 64'd0, 64'd1);
  endtask

  // Starts at a negedge with the controller idle; returns at a negedge with it idle again.
  task automatic run_txn(input int kind, input logic [15:0] a, input logic [15:0] wd);
    if (kind == 0) begin
      bus_pc = 1'b1; out_bus = a[7:0];
      @(negedge clk);
      bus_pc = 1'b0; out_bus = a[15:8];
      bus_mar = 1'($urandom); bus_mdr = 1'($urandom);
      wait_idle();
    end else begin
      bus_mar = 1'b1; out_bus = a[7:0];
      @(negedge clk);
      bus_mar = 1'b0; out_bus = a[15:8]; bus_pc = 1'($urandom);
      @(negedge clk);
      bus_pc = 1'b0;
      if (kind == 1) begin
        bus_mdr = 1'b1; out_bus = wd[7:0];
        @(negedge clk);
        bus_mdr = 1'b0; out_bus = wd[15:8];
      end else begin
        bus_mdr = 1'b0; out_bus = 8'($urandom);
      end
      wait_idle();
    end
  endtask

  // Transaction-level reference: what the core should see and what memory should be asked.
  task automatic model(input int kind, input logic [15:0] a, input logic [15:0] wd);
    logic [15:0] w;
    logic [15:0] a1;
    exp_b.delete(); exp_a.delete();
    if (kind == 0) begin
      w = mem[a];
      exp_a.push_back({1'b0, 1'b0, a, 16'h0});
      exp_b.push_back(w[7:0]); exp_b.push_back(w[15:8]);
      if (w[1:0] != 2'd0) begin
        a1 = a + 16'd1;
        w  = mem[a1];
        exp_a.push_back({1'b0, 1'b0, a1, 16'h0});
        exp_b.push_back(w[7:0]); exp_b.push_back(w[15:8]);
      end
    end else if (kind == 1) begin
      exp_a.push_back({1'b1, 1'b1, a, wd});
    end else begin
      w = mem[a];
      exp_a.push_back({1'b0, 1'b1, a, 16'h0});
      exp_b.push_back(w[7:0]); exp_b.push_back(w[15:8]);
    end
  endtask

  task automatic compare(input string tag);
    check({tag, "_nbytes"}, 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      check({tag, "_byte"}, 64'(got_b[i]), 64'(exp_b[i]));
    check({tag, "_naccess"}, 64'(got_a.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++) begin
      check({tag, "_addr"}, 64'(got_a[i].addr), 64'(exp_a[i].addr));
      check({tag, "_we_space"}, 64'({got_a[i].we, got_a[i].space}),
            64'({exp_a[i].we, exp_a[i].space}));
      if (exp_a[i].we) check({tag, "_wdata"}, 64'(got_a[i].wdata), 64'(exp_a[i].wdata));
    end
    got_b.delete(); got_a.delete();
  endtask

  initial begin : main
    vec_t        tbl[8];
    logic [15:0] ra, rwd;
    int          rk, n;

    tbl[0] = '{0, 16'h0005, 16'h0000, 16'hA1C0, 16'h0000, 2, 32'h0000A1C0, 1, 16'h0005, 16'h0000};
    tbl[1] = '{0, 16'h0000, 16'h0000, 16'h1235, 16'hFFFD, 4, 32'hFFFD1235, 2, 16'h0000, 16'h0001};
    tbl[2] = '{1, 16'h0006, 16'hFFFD, 16'h0000, 16'h0000, 0, 32'h00000000, 1, 16'h0006, 16'h0000};
    tbl[3] = '{2, 16'h0006, 16'h0000, 16'hFFFD, 16'h0000, 2, 32'h0000FFFD, 1, 16'h0006, 16'h0000};
    tbl[4] = '{0, 16'hFFFF, 16'h0000, 16'h00F3, 16'h8001, 4, 32'h800100F3, 2, 16'hFFFF, 16'h0000};
    tbl[5] = '{0, 16'h1234, 16'h0000, 16'h5678, 16'h0000, 2, 32'h00005678, 1, 16'h1234, 16'h0000};
    tbl[6] = '{0, 16'h4000, 16'h0000, 16'hABCE, 16'h0102, 4, 32'h0102ABCE, 2, 16'h4000, 16'h4001};
    tbl[7] = '{2, 16'hFFFF, 16'h0000, 16'h8000, 16'h0000, 2, 32'h00008000, 1, 16'hFFFF, 16'h0000};

    repeat (2) @(negedge clk);
    check("rst_receive_ready", 64'(ard_receive_ready), 64'd1);
    check("rst_data_ready", 64'(ard_data_ready), 64'd0);
    check("rst_outputs", 64'({in_bus, mem_req, mem_we, mem_space, err}), 64'd0);
    check("rst_mem_bus", 64'({mem_addr, mem_wdata}), 64'd0);
    rst = 1'b0;

    // Directed table; the first entry starts on the very first edge after reset release.
    for (int v = 0; v < 8; v++) begin
      if (tbl[v].kind != 1) begin
        mem[tbl[v].addr] = tbl[v].m0;
        if (tbl[v].kind == 0) mem[tbl[v].addr + 16'd1] = tbl[v].m1;
      end
      exp_b.delete(); exp_a.delete();
      for (int i = 0; i < tbl[v].nb; i++) exp_b.push_back(tbl[v].bytes[8*i +: 8]);
      exp_a.push_back({tbl[v].kind == 1, tbl[v].kind != 0, tbl[v].a0, tbl[v].wd});
      if (tbl[v].na > 1) exp_a.push_back({1'b0, 1'b0, tbl[v].a1, 16'h0});
      run_txn(tbl[v].kind, tbl[v].addr, tbl[v].wd);
      compare($sformatf("vec%0d", v));
    end
    check("store_effect", 64'(mem[16'h0006]), 64'hFFFD);

    // Reset while a fetch request is outstanding.
    hold_off = 1'b1;
    bus_pc = 1'b1; out_bus = 8'h22;
    @(negedge clk);
    bus_pc = 1'b0; out_bus = 8'h11;
    @(negedge clk);
    check("mid_req_pending", 64'({mem_req, mem_addr}), 64'({1'b1, 16'h1122}));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_req", 64'({mem_req, mem_we, mem_space}), 64'd0);
    check("mid_rst_ready", 64'({ard_receive_ready, ard_data_ready}), 64'b10);
    check("mid_rst_bus", 64'({in_bus, mem_addr}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    hold_off = 1'b0;
    @(negedge clk);
    check("mid_rst_no_bytes", 64'(got_b.size()), 64'd0);
    check("mid_rst_idle", 64'({ard_receive_ready, mem_req}), 64'b10);
    got_b.delete(); got_a.delete();

    // Stray acknowledges while idle must not start anything.
    stray = 1'b1;
    repeat (8) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_ack_idle", 64'({ard_receive_ready, mem_req, ard_data_ready}), 64'b100);
    check("stray_ack_quiet", 64'(got_b.size() + got_a.size()), 64'd0);

    // Randomized transactions against the model.
    for (int t = 0; t < 40; t++) begin
      rk  = $urandom_range(0, 2);
      ra  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      rwd = 16'($urandom);
      mem[ra]         = 16'($urandom);
      mem[ra + 16'd1] = 16'($urandom);
      stray = ($urandom_range(0, 3) == 0);
      model(rk, ra, rwd);
      run_txn(rk, ra, rwd);
      compare("rand");
    end
    stray = 1'b0;
    @(negedge clk);

`ifdef SERIAL_MEM_CTRL_TIMEOUT_EN
    hold_off = 1'b1;
    n = 0;
    bus_pc = 1'b1; out_bus = 8'h00;
    @(negedge clk);
    bus_pc = 1'b0; out_bus = 8'h01;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mem_req) n++;
      else if (n > 0) break;
    end
    check("timeout_len", 64'(n), 64'(TO));
    check("timeout_err", 64'({err, ard_receive_ready}), 64'b11);
    repeat (3) @(negedge clk);
    check("timeout_err_sticky", 64'(err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("timeout_err_clr", 64'(err), 64'd0);
    hold_off = 1'b0;
    got_b.delete(); got_a.delete();
`else
    n = 0;
    check("err_tied_low", 64'({err, 31'(n)}), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_mem_ctrl.md
SERIAL_MEM_CTRL -- requirements
Module: serial_mem_ctrl

Interface
REQ-001 Parameter TYPE_W, default 2: width of the instruction type field, located at fetched word bits [TYPE_W-1:0].
REQ-002 Parameter R_TYPE_CODE, default 0: type field value meaning a one-word instruction; every other value means two words (instruction plus immediate/address).
REQ-003 Parameter TO_CYCLES, default 255: memory acknowledge timeout, used only under REQ-030.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 out_bus  input  8  byte stream from the core.
REQ-007 bus_pc  input  1  core flag: PC low byte is on out_bus this cycle.
REQ-008 bus_mar  input  1  core flag: address low byte is on out_bus this cycle.
REQ-009 bus_mdr  input  1  core flag: store-data low byte is on out_bus this cycle.
REQ-010 in_bus  output  8  byte stream to the core.
REQ-011 ard_data_ready  output  1  in_bus carries a valid byte this cycle.
REQ-012 ard_receive_ready  output  1  controller is able to accept a core transfer.
REQ-013 mem_req, mem_we, mem_space (0 = instruction, 1 = data)  output  1 each  memory request qualifiers.
REQ-014 mem_addr, mem_wdata  output  16 each; mem_rdata  input  16; mem_ack  input  1.
REQ-015 err  output  1  sticky timeout error.

Function
REQ-016 States: IDLE, PC_HI, I_REQ, I_LO, I_HI, A_HI, D_CHK, ST_HI, ST_REQ, LD_REQ, LD_LO, LD_HI.
REQ-017 IDLE: ard_receive_ready = 1; bus_pc captures out_bus into addr[7:0] and goes to PC_HI; bus_mar does the same and goes to A_HI; bus_pc takes priority when both are set.
REQ-018 PC_HI: capture out_bus into addr[15:8], clear the word index, go to I_REQ.
REQ-019 I_REQ: mem_req = 1, mem_we = 0, mem_space = 0, mem_addr = addr + word index; hold until mem_ack, latch mem_rdata, go to I_LO.
REQ-020 I_LO then I_HI: ard_data_ready = 1 in both, in_bus = latched word [7:0] then [15:8], on consecutive cycles.
REQ-021 After I_HI: if word index is 0 and the type field is not R_TYPE_CODE, increment the index and go to I_REQ; otherwise go to IDLE. Address arithmetic wraps modulo 2^16 (0xFFFF + 1 = 0x0000).
REQ-022 A_HI: capture addr[15:8], go to D_CHK.
REQ-023 D_CHK: bus_mdr = 1 captures out_bus into wdata[7:0] and goes to ST_HI; bus_mdr = 0 goes to LD_REQ.
REQ-024 ST_HI: capture wdata[15:8], go to ST_REQ; ST_REQ: mem_req = 1, mem_we = 1, mem_space = 1, hold until mem_ack, go to IDLE.
REQ-025 LD_REQ: data read, hold until mem_ack; then LD_LO and LD_HI drive bytes as in REQ-020, then IDLE.
REQ-026 mem_req, mem_we, mem_space, mem_addr and mem_wdata hold stable while mem_req = 1 and no mem_ack has arrived; mem_ack outside a request state is ignored.
REQ-027 ard_receive_ready = 0 and ard_data_ready = 0 in every state that REQ-017 and REQ-020 do not name; core flags outside IDLE and D_CHK are ignored.

Reset
REQ-028 rst asserted at any time, including mid-transfer or mid-request: state = IDLE, and every output is 0 except ard_receive_ready, which goes to 1 as IDLE requires. err = 0, addr, wdata, the latched word and the word index = 0. No pending memory request survives.
REQ-029 The first IDLE capture can occur on the first rising edge after rst deasserts.

Configuration
REQ-030 SERIAL_MEM_CTRL_TIMEOUT_EN defined: an 8-bit counter increments each cycle in I_REQ, LD_REQ or ST_REQ. Reaching TO_CYCLES without mem_ack drops mem_req, sets err, and goes to IDLE. err stays set until reset.
REQ-031 Macro undefined: no counter exists, request states wait indefinitely, and err is tied to 0.

Verification
REQ-032 R-type fetch: bus_pc with bytes 0x05, 0x00; memory word 5 = 0xA1C0, ack after 1 cycle -> mem_addr 0x0005, in_bus 0xC0 then 0xA1 with ard_data_ready, then IDLE.
REQ-033 Two-word fetch: PC 0x0000, word0 type field = 1, word1 = 0xFFFD -> two reads at 0x0000 and 0x0001, four bytes in order, word1 sent as 0xFD then 0xFF.
REQ-034 Store: bus_mar with 0x06, 0x00, then bus_mdr with 0xFD, 0xFF -> one write with mem_space = 1, addr 0x0006, wdata 0xFFFD; no in_bus bytes.
REQ-035 Load: bus_mar with 0x06, 0x00, bus_mdr low next cycle, mem_rdata = 0xFFFD -> in_bus 0xFD, 0xFF.
REQ-036 Wrap and reset: two-word fetch at PC 0xFFFF -> second read at 0x0000. rst asserted during I_REQ -> IDLE next cycle, mem_req = 0, no bytes sent.
REQ-037 With the macro defined and mem_ack held low -> mem_req drops after TO_CYCLES cycles and err = 1 until rst.
